i2c_bus_arbiter: RTL and testbench
==================================

# i2c_bus_arbiter

Shares one I2C master controller between NUM_REQ independent requesters. Requests are picked round-robin. For each granted request the block drives the controller's enable/addr/rw/data_in handshake, waits for the transfer to finish through the controller's ready output, and returns read data with a one-cycle done pulse. It sits between the system-side agents (sensor pollers, config loaders) and the i2c master. It also guards the bus against a hung controller with a timeout.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- TIMEOUT, 1023: max clk cycles allowed in each wait state (LAUNCH, BUSY) before abort
- clk  in  1  system clock; same clock as the i2c controller's clk
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester transaction request level
- req_addr  in  7*NUM_REQ  7-bit target address; slice i belongs to requester i
- req_rw  in  NUM_REQ  1 = read, 0 = write
- req_wdata  in  8*NUM_REQ  write byte per requester
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse with done when the transaction aborts on timeout
- rdata  out  8  read byte, valid from the done cycle until the next done
- ctl_enable  out  1  controller enable
- ctl_addr  out  7  controller addr
- ctl_rw  out  1  controller rw
- ctl_data_in  out  8  controller data_in
- ctl_ready  in  1  controller ready (high = controller idle)
- ctl_data_out  in  8  controller data_out

## Operation
- States: IDLE, ARB, LAUNCH, BUSY, DONE.
- IDLE: if any req bit is set and ctl_ready=1, go to ARB. Otherwise stay.
- ARB: select the first set req bit, searching upward from rr_ptr with wrap.
  - Register gnt (one-hot).
  - Latch req_addr, req_rw and req_wdata of the winner into ctl_addr, ctl_rw and ctl_data_in.
  - Set rr_ptr = (winner+1) mod NUM_REQ.
  - If req is all-zero here (dropped), return to IDLE with no grant.
- LAUNCH: ctl_enable=1. When ctl_ready=0 is seen, clear ctl_enable and go to BUSY.
  - ctl_enable must be low before the controller finishes its ack phase, so the controller terminates with STOP and does not chain.
- BUSY: ctl_enable=0. When ctl_ready=1 is seen, capture rdata <= ctl_data_out if ctl_rw=1 (rdata unchanged on writes), then go to DONE.
- DONE: pulse done[winner] for one cycle, clear gnt, return to IDLE.
- Timeout: a 10-bit wait counter clears on entry to LAUNCH and to BUSY and increments each cycle in those states.
  - When it reaches TIMEOUT: clear ctl_enable, go to DONE with err=1.
  - rdata is unchanged on timeout.
- ctl_addr, ctl_rw and ctl_data_in stay stable from ARB until the next ARB.
- Requesters hold req and payload until done. Deasserting req after the grant is ignored: the transaction completes and done still pulses.
- NACK is not distinguished by this block. The controller returns ready after STOP, and this block reports normal done.
- Asynchronous reset mid-transaction clears all outputs and the state immediately. The controller shares the reset domain, so it also returns to IDLE.

## Timing
- Reset values: gnt=0, done=0, err=0, rdata=0x00, ctl_enable=0, ctl_addr=0, ctl_rw=0, ctl_data_in=0x00, rr_ptr=0, state=IDLE.
- Request latency: req high in IDLE at cycle n → gnt and ctl_* valid at n+2, ctl_enable high at n+2.
- ctl_enable stays high for at least 1 cycle and until ctl_ready is seen low. The controller samples on its divided clock, so the hold is typically 2-4 clk cycles.
- done is asserted 1 cycle after ctl_ready is seen high. rdata is valid in that same cycle.
- Back-to-back: the next ARB occurs at the earliest 1 cycle after DONE, which gives 2 idle cycles between transactions.
- If two requests arrive in the same cycle, the lower index at or above rr_ptr wins.
- Fairness: with all req bits held high, grants rotate 0,1,2,...,NUM_REQ-1,0.

## Test plan
- Single write: req[1]=1, addr 0x50, rw=0, wdata 0xA5, controller model ACKs.
  - Expect ctl_addr=0x50, ctl_data_in=0xA5 and gnt=0010.
  - Expect done[1] pulse, err=0, rdata unchanged.
- Single read: req[2]=1, addr 0x48, rw=1, slave returns 0x3C.
  - Expect rdata=0x3C in the done[2] cycle.
  - Expect ctl_enable to fall within 1 cycle of ctl_ready falling.
- All four req held high for 8 transactions.
  - Expect grant order 0,1,2,3,0,1,2,3, exactly one gnt bit at a time, and no overlap of ctl_enable with a busy controller.
- Simultaneous req[3] and req[0] with rr_ptr=2: expect req[3] granted first, then req[0].
- Controller model holds ctl_ready=1 (never starts) with TIMEOUT=15.
  - Expect err and done pulse 17 cycles after the grant, ctl_enable low, then the arbiter returns to IDLE.
- Assert rst_n low while in BUSY.
  - Expect gnt, ctl_enable and done all 0 immediately.
  - After release, a new req[0] is granted with rr_ptr=0.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// Round-robin share of one I2C master controller among NUM_REQ requesters, with a hang timeout.
// Latency: req -> gnt/ctl_enable in 2 clk, done 1 clk after ctl_ready returns; backpressure: requesters hold req until done.
module i2c_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic                 ctl_enable,
  output logic [6:0]           ctl_addr,
  output logic                 ctl_rw,
  output logic [7:0]           ctl_data_in,
  input  logic                 ctl_ready,
  input  logic [7:0]           ctl_data_out
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] GNT_ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LAUNCH, S_BUSY, S_DONE} state_t;

  state_t          state, next_state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   rr_nxt;
  logic            win_vld;
  logic [9:0]      wait_cnt;
  logic            wait_hit;
  logic            abort;

  assign wait_hit = (wait_cnt == 10'(TIMEOUT));

  // First set request at or above rr_ptr, wrapping around.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    rr_nxt = PW'((int'(win_idx) + 1) % NUM_REQ);
  end

  always_comb begin
    next_state = state;
    abort      = 1'b0;
    case (state)
      S_IDLE:   if (|req && ctl_ready) next_state = S_ARB;
      S_ARB:    next_state = win_vld ? S_LAUNCH : S_IDLE;
      S_LAUNCH: begin
        if (!ctl_ready) begin
          next_state = S_BUSY;
        end else if (wait_hit) begin
          next_state = S_DONE;
          abort      = 1'b1;
        end
      end
      S_BUSY: begin
        if (ctl_ready) begin
          next_state = S_DONE;
        end else if (wait_hit) begin
          next_state = S_DONE;
          abort      = 1'b1;
        end
      end
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= '0;
      done        <= '0;
      err         <= 1'b0;
      rdata       <= 8'h00;
      ctl_enable  <= 1'b0;
      ctl_addr    <= 7'h00;
      ctl_rw      <= 1'b0;
      ctl_data_in <= 8'h00;
      rr_ptr      <= '0;
      wait_cnt    <= '0;
    end else begin
      // Enable drops the cycle after the controller goes busy, so it stops after one byte.
      ctl_enable <= (next_state == S_LAUNCH);
      done       <= '0;
      err        <= 1'b0;

      if (state == S_ARB && win_vld) begin
        gnt         <= GNT_ONE << win_idx;
        ctl_addr    <= req_addr[int'(win_idx)*7 +: 7];
        ctl_rw      <= req_rw[win_idx];
        ctl_data_in <= req_wdata[int'(win_idx)*8 +: 8];
        rr_ptr      <= rr_nxt;
      end

      if (state == S_BUSY && ctl_ready && ctl_rw) rdata <= ctl_data_out;

      if (next_state == S_DONE) begin
        done <= gnt;
        err  <= abort;
      end

      if (state == S_DONE) gnt <= '0;

      if (next_state != state)
        wait_cnt <= '0;
      else if (state == S_LAUNCH || state == S_BUSY)
        wait_cnt <= wait_cnt + 10'd1;
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter driving a simple I2C-controller model (start delay, busy window, optional hang).
module tb_i2c_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [N-1:0]   req_rw = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           err;
  logic [7:0]     rdata;
  logic           ctl_enable;
  logic [6:0]     ctl_addr;
  logic           ctl_rw;
  logic [7:0]     ctl_data_in;
  logic           ctl_ready = 1'b1;
  logic [7:0]     ctl_data_out = 8'h00;

  int checks = 0;
  int errors = 0;

  bit         hang = 1'b0;
  int         busy_len = 4;
  logic [7:0] slave_data = 8'h00;
  bit         m_busy = 1'b0;
  int         m_sdly = 0;
  int         m_bcnt = 0;
  int         overlap_viol = 0;
  int         multi_gnt_viol = 0;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .ctl_enable(ctl_enable), .ctl_addr(ctl_addr), .ctl_rw(ctl_rw),
    .ctl_data_in(ctl_data_in), .ctl_ready(ctl_ready), .ctl_data_out(ctl_data_out)
  );

  // Monitors sample before the controller model updates in the same negedge.
  always @(negedge clk) begin
    if (ctl_enable && !ctl_ready) overlap_viol++;
    if ($countones(gnt) > 1) multi_gnt_viol++;
    if (!rst_n) begin
      ctl_ready = 1'b1;
      m_busy    = 1'b0;
      m_sdly    = 0;
    end else if (m_busy) begin
      if (m_bcnt == 0) begin
        ctl_ready    = 1'b1;
        ctl_data_out = slave_data;
        m_busy       = 1'b0;
      end else begin
        m_bcnt--;
      end
    end else if (ctl_enable && !hang && ctl_ready) begin
      if (m_sdly >= 1) begin
        ctl_ready = 1'b0;
        m_busy    = 1'b1;
        m_bcnt    = busy_len;
        m_sdly    = 0;
      end else begin
        m_sdly++;
      end
    end else begin
      m_sdly = 0;
    end
  end

  task automatic set_payload(input int i, input logic [6:0] a, input logic rw, input logic [7:0] d);
    req_addr[i*7 +: 7]  = a;
    req_rw[i]           = rw;
    req_wdata[i*8 +: 8] = d;
  endtask

  task automatic wait_gnt();
    for (int t = 0; t < 60 && gnt == '0; t++) @(negedge clk);
  endtask

  task automatic wait_done();
    for (int t = 0; t < 60 && done == '0; t++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk);
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b exp %b", gnt, 4'b0); end
    checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done got %b exp %b", done, 4'b0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
    checks++; if (ctl_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %b exp 0", ctl_enable); end
    checks++; if ({ctl_addr, ctl_rw, ctl_data_in} !== 16'h0000) begin
      errors++; $display("FAIL reset_ctl got %h/%b/%h exp 00/0/00", ctl_addr, ctl_rw, ctl_data_in);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [3:0] e_gnt;
    logic [6:0] e_addr;
    for (int i = 0; i < N; i++) set_payload(i, 7'h10 + 7'(i), 1'b0, 8'h80 + 8'(i));
    req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      e_gnt  = 4'b0001 << (n % 4);
      e_addr = 7'h10 + 7'(n % 4);
      wait_gnt();
      checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", n, gnt, e_gnt); end
      checks++; if (ctl_addr !== e_addr) begin errors++; $display("FAIL rr_addr[%0d] got %h exp %h", n, ctl_addr, e_addr); end
      wait_done();
      checks++; if (done !== e_gnt) begin errors++; $display("FAIL rr_done[%0d] got %b exp %b", n, done, e_gnt); end
      if (n == 7) req = '0;
      @(negedge clk);
    end
    checks++; if (multi_gnt_viol !== 0) begin errors++; $display("FAIL rr_onehot got %0d exp 0", multi_gnt_viol); end
    checks++; if (overlap_viol !== 0) begin errors++; $display("FAIL rr_overlap got %0d exp 0", overlap_viol); end
  endtask

  task automatic test_single_write();
    set_payload(1, 7'h50, 1'b0, 8'hA5);
    req = 4'b0010;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL wr_gnt_early got %b exp 0000", gnt); end
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wr_gnt got %b exp 0010", gnt); end
    checks++; if (ctl_enable !== 1'b1) begin errors++; $display("FAIL wr_enable got %b exp 1", ctl_enable); end
    checks++; if ({ctl_addr, ctl_rw, ctl_data_in} !== {7'h50, 1'b0, 8'hA5}) begin
      errors++; $display("FAIL wr_ctl got %h/%b/%h exp 50/0/a5", ctl_addr, ctl_rw, ctl_data_in);
    end
    wait_done();
    checks++; if (done !== 4'b0010) begin errors++; $display("FAIL wr_done got %b exp 0010", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", err); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata got %h exp 00", rdata); end
    req = '0;
    @(negedge clk);
    checks++; if ({done, gnt} !== 8'h00) begin errors++; $display("FAIL wr_after got done %b gnt %b exp 0000 0000", done, gnt); end
  endtask

  task automatic test_single_read();
    set_payload(2, 7'h48, 1'b1, 8'h00);
    slave_data = 8'h3C;
    req = 4'b0100;
    wait_gnt();
    checks++; if ({ctl_addr, ctl_rw} !== {7'h48, 1'b1}) begin
      errors++; $display("FAIL rd_ctl got %h/%b exp 48/1", ctl_addr, ctl_rw);
    end
    wait_done();
    checks++; if (done !== 4'b0100) begin errors++; $display("FAIL rd_done got %b exp 0100", done); end
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata got %h exp 3c", rdata); end
    req = '0;
    repeat (2) @(negedge clk);
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata_hold got %h exp 3c", rdata); end
    checks++; if (overlap_viol !== 0) begin errors++; $display("FAIL rd_overlap got %0d exp 0", overlap_viol); end
  endtask

  task automatic test_simultaneous();
    // Transaction on requester 1 leaves the pointer at 2.
    set_payload(1, 7'h21, 1'b0, 8'h21);
    req = 4'b0010;
    wait_done();
    req = '0;
    @(negedge clk);
    set_payload(3, 7'h33, 1'b0, 8'h33);
    set_payload(0, 7'h0A, 1'b0, 8'h0A);
    req = 4'b1001;
    wait_gnt();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL sim_first got %b exp 1000", gnt); end
    checks++; if (ctl_addr !== 7'h33) begin errors++; $display("FAIL sim_first_addr got %h exp 33", ctl_addr); end
    wait_done();
    req = 4'b0001;
    @(negedge clk);
    wait_gnt();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL sim_second got %b exp 0001", gnt); end
    checks++; if (ctl_data_in !== 8'h0A) begin errors++; $display("FAIL sim_second_data got %h exp 0a", ctl_data_in); end
    wait_done();
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL sim_done got %b exp 0001", done); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int cyc;
    hang = 1'b1;
    ctl_data_out = 8'hEE;
    set_payload(2, 7'h22, 1'b1, 8'h00);
    req = 4'b0100;
    wait_gnt();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL to_gnt got %b exp 0100", gnt); end
    // gnt is first visible one cycle after ARB, so the 17-cycle abort lands 16 cycles later.
    cyc = 0;
    while (done == '0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 16) begin errors++; $display("FAIL to_latency got %0d exp 16", cyc); end
    checks++; if ({done, err} !== {4'b0100, 1'b1}) begin errors++; $display("FAIL to_done_err got %b/%b exp 0100/1", done, err); end
    checks++; if (ctl_enable !== 1'b0) begin errors++; $display("FAIL to_enable got %b exp 0", ctl_enable); end
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL to_rdata got %h exp 3c", rdata); end
    req  = '0;
    hang = 1'b0;
    @(negedge clk);
    checks++; if ({gnt, done, err} !== 9'b0) begin errors++; $display("FAIL to_idle got %b/%b/%b exp 0", gnt, done, err); end
  endtask

  task automatic test_reset_busy();
    busy_len = 10;
    set_payload(1, 7'h11, 1'b0, 8'h11);
    req = 4'b0010;
    wait_gnt();
    for (int t = 0; t < 30 && !(ctl_ready == 1'b0 && ctl_enable == 1'b0); t++) @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rb_pre_gnt got %b exp 0010", gnt); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({gnt, ctl_enable, done} !== 9'b0) begin
      errors++; $display("FAIL rb_async got gnt %b en %b done %b exp 0", gnt, ctl_enable, done);
    end
    req = '0;
    @(negedge clk);
    @(negedge clk);
    set_payload(0, 7'h05, 1'b0, 8'h05);
    set_payload(3, 7'h03, 1'b0, 8'h03);
    rst_n    = 1'b1;
    busy_len = 4;
    req      = 4'b1001;
    wait_gnt();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rb_regrant got %b exp 0001", gnt); end
    wait_done();
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL rb_done got %b exp 0001", done); end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_write();
    test_single_read();
    test_simultaneous();
    test_timeout();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
